// File: rtl/hb_task_consumer.sv
// Single-tile worker endpoint: accepts one task word, counts down its duration,
// then reports completion and keeps completion / busy-cycle statistics.
//
// state  | meaning
// IDLE   | waiting for a task word, task_ready high
// EXEC   | counting down the effective duration, busy high
// REPORT | presenting the completion record until done_ready
module hb_task_consumer #(
  parameter int MAX_DUR = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        task_valid,
  input  logic [31:0] task_data,
  output logic        task_ready,
  output logic        done_valid,
  output logic [31:0] done_data,
  output logic        done_clamped,
  input  logic        done_ready,
  output logic        busy,
  output logic [31:0] completed_count,
  output logic [31:0] busy_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [15:0] MAX_DUR_W = 16'(MAX_DUR);

  state_t      state;
  logic [15:0] remain;
  logic [15:0] req_dur;
  logic [15:0] eff_dur;
  logic        eff_clamped;

  assign req_dur = task_data[15:0];

  always_comb begin
    eff_dur     = req_dur;
    eff_clamped = 1'b0;
    if (req_dur == 16'd0) begin
      eff_dur = 16'd1;
    end else if (req_dur > MAX_DUR_W) begin
      eff_dur     = MAX_DUR_W;
      eff_clamped = 1'b1;
    end
  end

  assign task_ready = (state == IDLE);
  assign busy       = (state == EXEC);
  assign done_valid = (state == REPORT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      remain          <= 16'd0;
      done_data       <= 32'd0;
      done_clamped    <= 1'b0;
      completed_count <= 32'd0;
      busy_cycles     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (task_valid) begin
            state        <= EXEC;
            remain       <= eff_dur;
            done_data    <= {task_data[31:16], eff_dur};
            done_clamped <= eff_clamped;
          end
        end
        EXEC: begin
          if (busy_cycles != 32'hFFFF_FFFF) begin
            busy_cycles <= busy_cycles + 32'd1;
          end
          remain <= remain - 16'd1;
          // the last EXEC cycle is the one that sees a count of 1
          if (remain == 16'd1) begin
            state <= REPORT;
          end
        end
        REPORT: begin
          if (done_ready) begin
            state           <= IDLE;
            completed_count <= completed_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_task_consumer.sv
// Self-checking bench for hb_task_consumer: completion records go through a
// scoreboard queue filled at task acceptance, plus per-scenario timing checks.
module tb_hb_task_consumer;

  localparam int MAX_DUR = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        task_valid;
  logic [31:0] task_data;
  logic        task_ready;
  logic        done_valid;
  logic [31:0] done_data;
  logic        done_clamped;
  logic        done_ready;
  logic        busy;
  logic [31:0] completed_count;
  logic [31:0] busy_cycles;

  always #5 clk = ~clk;

  hb_task_consumer #(.MAX_DUR(MAX_DUR)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .task_valid      (task_valid),
    .task_data       (task_data),
    .task_ready      (task_ready),
    .done_valid      (done_valid),
    .done_data       (done_data),
    .done_clamped    (done_clamped),
    .done_ready      (done_ready),
    .busy            (busy),
    .completed_count (completed_count),
    .busy_cycles     (busy_cycles)
  );

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  longint      exp_busy_sum;

  // expected {clamped, task_id, eff_dur}
  function automatic logic [32:0] model(input logic [31:0] w);
    logic [15:0] d;
    d = w[15:0];
    if (d == 16'd0) return {1'b0, w[31:16], 16'd1};
    if (d > 16'(MAX_DUR)) return {1'b1, w[31:16], 16'(MAX_DUR)};
    return {1'b0, w};
  endfunction

  // Inputs are set just after a falling edge; this records the handshakes the
  // coming rising edge will perform, then advances to the next falling edge.
  task automatic step();
    logic [32:0] e;
    if (reset_n && task_valid && task_ready) begin
      e = model(task_data);
      exp_q.push_back(e);
      exp_busy_sum += longint'(e[15:0]);
    end
    if (reset_n && done_valid && done_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got data=%h with no task outstanding", done_data);
      end else begin
        e = exp_q.pop_front();
        if ({done_clamped, done_data} !== e) begin
          errors++;
          $display("FAIL done_record got clamp=%0b data=%h expected clamp=%0b data=%h",
                   done_clamped, done_data, e[32], e[31:0]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    task_valid = 1'b0;
    task_data  = 32'd0;
    done_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    exp_q.delete();
    exp_busy_sum = 0;
  endtask

  // Runs one task with done_ready high; reports busy cycles and the cycle
  // index (1 = cycle after accept) where done_valid / task_ready first appear.
  task automatic run_single(input logic [31:0] w, output int nb, output int fdv, output int ftr);
    int i;
    nb = 0; fdv = 0; ftr = 0;
    task_valid = 1'b1;
    task_data  = w;
    done_ready = 1'b1;
    i = 0;
    while (!task_ready && i < 100) begin
      step();
      i++;
    end
    step();
    task_valid = 1'b0;
    for (i = 1; i <= MAX_DUR + 20 && ftr == 0; i++) begin
      if (busy) nb++;
      if (done_valid && fdv == 0) fdv = i;
      if (task_ready) ftr = i;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if ({task_ready, busy, done_valid} !== 3'b100 || completed_count !== 32'd0 ||
        busy_cycles !== 32'd0 || done_data !== 32'd0 || done_clamped !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b busy=%0b dv=%0b cc=%0d bc=%0d dd=%h cl=%0b expected 1 0 0 0 0 0 0",
               task_ready, busy, done_valid, completed_count, busy_cycles, done_data, done_clamped);
    end
  endtask

  task automatic test_basic();
    int nb, fdv, ftr;
    do_reset();
    run_single(32'h0007_0005, nb, fdv, ftr);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL basic_busy got %0d expected 5", nb); end
    checks++;
    if (fdv !== 6) begin errors++; $display("FAIL basic_done_cycle got %0d expected 6", fdv); end
    checks++;
    if (ftr !== 7) begin errors++; $display("FAIL basic_ready_cycle got %0d expected 7", ftr); end
    checks++;
    if (completed_count !== 32'd1) begin
      errors++; $display("FAIL basic_completed got %0d expected 1", completed_count);
    end
    checks++;
    if (busy_cycles !== 32'd5) begin
      errors++; $display("FAIL basic_busy_cycles got %0d expected 5", busy_cycles);
    end
  endtask

  task automatic test_zero_clamp();
    int nb, fdv, ftr;
    do_reset();
    run_single(32'h0001_0000, nb, fdv, ftr);
    checks++;
    if (nb !== 1 || ftr !== 3) begin
      errors++; $display("FAIL zero_dur got busy=%0d ready=%0d expected 1 3", nb, ftr);
    end
    run_single(32'h0002_FFFF, nb, fdv, ftr);
    checks++;
    if (nb !== MAX_DUR || fdv !== MAX_DUR + 1) begin
      errors++; $display("FAIL clamp_dur got busy=%0d done=%0d expected %0d %0d", nb, fdv, MAX_DUR, MAX_DUR + 1);
    end
    run_single(32'h0009_0400, nb, fdv, ftr);
    checks++;
    if (nb !== MAX_DUR) begin
      errors++; $display("FAIL max_dur got busy=%0d expected %0d", nb, MAX_DUR);
    end
    run_single(32'h000A_0002, nb, fdv, ftr);
    checks++;
    if (nb !== 2 || ftr !== 4) begin
      errors++; $display("FAIL short_dur got busy=%0d ready=%0d expected 2 4", nb, ftr);
    end
    checks++;
    if (longint'(busy_cycles) !== exp_busy_sum || completed_count !== 32'd4) begin
      errors++; $display("FAIL clamp_counters got bc=%0d cc=%0d expected %0d 4", busy_cycles, completed_count, exp_busy_sum);
    end
  endtask

  task automatic test_backpressure();
    int  i;
    bit  stable;
    do_reset();
    task_valid = 1'b1;
    task_data  = 32'h0004_0003;
    done_ready = 1'b0;
    step();
    task_data = 32'h0005_0002;
    i = 0;
    while (!done_valid && i < 50) begin
      step();
      i++;
    end
    stable = done_valid;
    for (int k = 0; k < 10; k++) begin
      if (!done_valid || task_ready || busy || done_data !== 32'h0004_0003 || done_clamped !== 1'b0)
        stable = 1'b0;
      step();
    end
    checks++;
    if (!stable || !done_valid || done_data !== 32'h0004_0003) begin
      errors++; $display("FAIL bp_hold got dv=%0b rdy=%0b data=%h expected 1 0 00040003", done_valid, task_ready, done_data);
    end
    done_ready = 1'b1;
    step();
    checks++;
    if (task_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%0b busy=%0b dv=%0b expected 1 0 0", task_ready, busy, done_valid);
    end
    step();
    checks++;
    if (busy !== 1'b1 || exp_q.size() !== 1) begin
      errors++; $display("FAIL bp_next_accept got busy=%0b queued=%0d expected 1 1", busy, exp_q.size());
    end
    task_valid = 1'b0;
    i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      step();
      i++;
    end
    checks++;
    if (exp_q.size() !== 0 || completed_count !== 32'd2) begin
      errors++; $display("FAIL bp_drain got queued=%0d cc=%0d expected 0 2", exp_q.size(), completed_count);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    do_reset();
    task_valid = 1'b1;
    task_data  = 32'h0003_0064;
    done_ready = 1'b1;
    step();
    task_valid = 1'b0;
    repeat (19) step();
    checks++;
    if (busy !== 1'b1 || busy_cycles !== 32'd19) begin
      errors++; $display("FAIL mid_exec_pre got busy=%0b bc=%0d expected 1 19", busy, busy_cycles);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_q.delete();
    exp_busy_sum = 0;
    checks++;
    if ({task_ready, busy, done_valid} !== 3'b100 || completed_count !== 32'd0 ||
        busy_cycles !== 32'd0 || done_data !== 32'd0 || done_clamped !== 1'b0) begin
      errors++;
      $display("FAIL mid_exec_reset got rdy=%0b busy=%0b dv=%0b cc=%0d bc=%0d dd=%h expected 1 0 0 0 0 0",
               task_ready, busy, done_valid, completed_count, busy_cycles, done_data);
    end
    seen = 1'b0;
    repeat (150) begin
      if (done_valid || busy) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_exec_ghost got activity=1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    bit          acc;
    int          t;
    do_reset();
    for (int n = 0; n < 100; n++) begin
      w = {16'(16'h0100 + n), 16'($urandom_range(0, 1200))};
      task_valid = 1'b1;
      task_data  = w;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 3000) begin
        done_ready = 1'($urandom_range(0, 1));
        acc = task_ready;
        step();
        t++;
      end
      task_valid = 1'b0;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL stream_accept_timeout task %0d got no accept expected accept", n);
        break;
      end
    end
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      done_ready = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    done_ready = 1'b0;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL stream_drain got queued=%0d expected 0", exp_q.size());
    end
    checks++;
    if (completed_count !== 32'd100) begin
      errors++; $display("FAIL stream_completed got %0d expected 100", completed_count);
    end
    checks++;
    if (longint'(busy_cycles) !== exp_busy_sum) begin
      errors++; $display("FAIL stream_busy_cycles got %0d expected %0d", busy_cycles, exp_busy_sum);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    task_valid = 1'b0;
    task_data  = 32'd0;
    done_ready = 1'b0;
    exp_busy_sum = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_clamp();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hb_task_consumer.md
# hb_task_consumer

Worker-side endpoint of the task queue. It accepts 32-bit task words from the distributor's output channel with a valid/ready handshake and executes each task by counting down its encoded duration. It then reports completion on a valid/ready done channel and keeps completion and busy-cycle statistics. One instance sits behind each distributor output port and models a single HammerBlade worker tile.

## Interface
Parameters:
- MAX_DUR, default 1024: largest executable duration in cycles. Requested durations above it are clamped. Legal range is 1..65535.

Ports:
- clk, input, 1: sole clock. All logic updates on the rising edge.
- reset_n, input, 1: reset, synchronous and active-low.
- task_valid, input, 1: the distributor presents a task word.
- task_data, input, 32: task word. [31:16] = task_id, [15:0] = requested duration.
- task_ready, output, 1: the consumer can accept a task this cycle.
- done_valid, output, 1: a completion record is presented.
- done_data, output, 32: completion record. [31:16] = task_id, [15:0] = executed cycles.
- done_clamped, output, 1: the reported task had its duration clamped. Valid while done_valid is high.
- done_ready, input, 1: the sink accepts the completion record.
- busy, output, 1: a task is executing.
- completed_count, output, 32: number of done handshakes. Wraps modulo 2^32.
- busy_cycles, output, 32: number of cycles spent in EXEC. Saturates at 0xFFFF_FFFF.

## Operation
- FSM states and transitions:
  - IDLE -> EXEC on task_valid && task_ready.
  - EXEC -> REPORT when the remaining-cycle counter is 1.
  - REPORT -> IDLE on done_valid && done_ready.
- Output decode from state: task_ready = (state == IDLE). busy = (state == EXEC). done_valid = (state == REPORT).
- On accept, the consumer latches task_id and computes eff_dur:
  - requested duration 0 -> eff_dur = 1.
  - requested duration > MAX_DUR -> eff_dur = MAX_DUR, and the clamped flag is set.
  - otherwise eff_dur = requested duration.
- On accept, the remaining-cycle counter loads eff_dur.
- In EXEC the counter decrements once per cycle, and busy_cycles increments (saturating).
- In REPORT:
  - done_data = {task_id, eff_dur}, stable until the handshake completes.
  - done_clamped = the latched clamped flag.
- completed_count increments by 1 on each done handshake.
- While task_ready is low, task_valid and task_data are ignored. The producer must hold the task until ready.
- Only one task is in flight. There is no internal queue.
- Reset values: state = IDLE, so task_ready = 1, busy = 0, done_valid = 0. done_data = 0, done_clamped = 0, completed_count = 0, busy_cycles = 0, counter = 0.

## Timing
- A task accepted at edge k occupies EXEC for exactly eff_dur cycles, covering edges k+1 .. k+eff_dur.
- done_valid is first high in the cycle after edge k+eff_dur.
- If done_ready is high the first cycle done_valid is high, task_ready returns high one cycle later.
- Minimum accept-to-accept spacing is eff_dur + 2 cycles.
- done_ready held low: REPORT persists indefinitely, done_data and done_clamped stay stable, and no new task is accepted.
- done_ready high outside REPORT has no effect.
- A task_valid pulse in the same cycle as the done handshake is not accepted, because task_ready is still 0.
- reset_n low at any edge, including mid-EXEC or mid-REPORT: the next cycle shows all reset values. The in-flight task is discarded, no done record is issued, and the counters clear.
- Duration boundaries:
  - eff_dur = 1: exactly one EXEC cycle.
  - eff_dur = MAX_DUR: MAX_DUR EXEC cycles, with done_clamped = 0 if the request equalled MAX_DUR.

## Test plan
- Reset then idle: hold reset_n = 0 for 3 cycles, release. Required: task_ready = 1, busy = 0, done_valid = 0, both counters = 0.
- Basic task: task_data = 0x0007_0005 with done_ready = 1. Required:
  - busy high for exactly 5 cycles.
  - done_data = 0x0007_0005, done_clamped = 0.
  - completed_count = 1, busy_cycles = 5.
  - task_ready high again 7 cycles after accept.
- Zero and clamp: task 0x0001_0000 -> done_data = 0x0001_0001, 1 busy cycle. Task 0x0002_FFFF with MAX_DUR = 1024 -> done_data = 0x0002_0400, done_clamped = 1, busy for 1024 cycles.
- Done backpressure: done_ready = 0 for 10 cycles after done_valid rises while task_valid is held high with a new task. Required:
  - done_data stays stable and task_ready stays 0 throughout.
  - After done_ready = 1, the new task is accepted exactly one cycle after the handshake.
- Reset mid-EXEC: accept task 0x0003_0064, assert reset_n = 0 at cycle 20 of EXEC. Required: no done_valid ever appears for task 3, and all outputs return to reset values on the following cycle.
- Back-to-back stream: 100 random tasks (durations 0..1200) with random done_ready. Required:
  - in-order ids matching the inputs.
  - completed_count = 100.
  - busy_cycles equal to the sum of eff_dur over the 100 tasks.
